key_loader: RTL and testbench
=============================

// Module: key_loader
// PURPOSE
//   Serial key-delivery stage directly upstream of the locked combinational core.
//   Receives the secret key bit-serially from tamper-proof storage and checks one even-parity bit.
//   Drives the core's parallel key[] port.
//   Holds key at all-zero (a wrong key) until a clean load completes.
//   Counts consecutive parity failures and permanently locks out after MAX_FAIL.
// PARAMETERS
//   KEY_W     8   key width in bits; must be >= 2; equals the core's key[] width
//   MAX_FAIL  3   consecutive parity failures before LOCKOUT; must be >= 1
// PORTS
//   clk          in   1      single clock; all logic on rising edge
//   rst          in   1      synchronous, active-high reset
//   start        in   1      1-cycle pulse: begin a new key load
//   zeroize      in   1      level: clear key and return to IDLE
//   key_in_valid in   1      serial bit valid from key storage
//   key_in_bit   in   1      serial key/parity bit, key LSB first
//   key_in_ready out  1      stage accepts a bit (high in SHIFT, PARITY)
//   key          out  KEY_W  parallel key to locked core
//   key_valid    out  1      key holds a verified value
//   busy         out  1      high in SHIFT or PARITY
//   error        out  1      high in ERROR or LOCKOUT
//   lockout      out  1      high in LOCKOUT
// BEHAVIOUR
//   Reset: state=IDLE, shift reg=0, bit count=0, fail count=0, key=0, all 1-bit outputs 0.
//   Every output is registered or decoded from the registered state; no comb path in->out.
//   Handshake: a bit is consumed on any edge where key_in_valid && key_in_ready.
//     key_in_valid without key_in_ready is ignored; the source holds the bit.
//   Priority on one edge, highest first: rst > zeroize > start > bit transfer.
//   States:
//     IDLE    key=0. start -> SHIFT. shift reg, bit count cleared.
//     SHIFT   sreg <= {key_in_bit, sreg[KEY_W-1:1]}; count++ per bit.
//             The transfer that takes count to KEY_W -> PARITY.
//     PARITY  On transfer, parity ok iff key_in_bit == ^sreg (even parity over key+bit).
//             ok: key <= sreg, fail count <= 0 -> LOADED.
//             fail: key <= 0, fail count++ ->
//               LOCKOUT if new count == MAX_FAIL, else ERROR.
//     LOADED  key=stored value, key_valid=1. start -> SHIFT.
//             key is driven to 0 and key_valid=0 from the edge start is taken.
//     ERROR   key=0, error=1. start -> SHIFT (retry). fail count is retained.
//     LOCKOUT key=0, error=1, lockout=1. Ignores start and zeroize; only rst exits.
//   start in SHIFT or PARITY restarts the load (counters cleared, key stays 0).
//     A bit transferred on that same edge is discarded.
//   zeroize in any state except LOCKOUT -> IDLE on that edge.
//     Clears sreg and key and drops key_valid; fail count is retained (not a retry bypass).
//   Latency: key/key_valid update on the edge that accepts the parity bit, visible next cycle.
//     Minimum load = KEY_W+1 accepted bits.
//   Bit count is $clog2(KEY_W+1) bits wide and never wraps.
//     Fail count saturates at MAX_FAIL.
//   rst mid-load: immediate return to reset values; a partial key is never driven.
// TESTING (KEY_W=8, MAX_FAIL=3)
//   Clean load: start, then bits of 8'hA5 LSB-first (1,0,1,0,0,1,0,1), parity 0, valid every cycle
//     -> key=8'hA5, key_valid=1 the cycle after the 9th transfer. busy 0 the same cycle.
//   Gapped valid: same 9 bits with key_in_valid low on alternate cycles -> same result, no lost or duplicated bits.
//   Bad parity x3: load 8'h01 with parity 0 three times, start between attempts
//     -> ERROR after the 1st and 2nd, LOCKOUT after the 3rd. key=0 throughout.
//     start/zeroize ignored; rst clears lockout.
//   Fail reset: 2 bad loads, then a good 8'h3C (parity 0) -> LOADED, fail count 0.
//     A further 2 bad loads give ERROR, not LOCKOUT.
//   Restart/zeroize: start after 4 bits -> count restarts, the next 9 bits load correctly.
//     zeroize in LOADED (key=8'hA5) -> next cycle key=0, key_valid=0, state IDLE.
//   Simultaneous: start and a valid bit on the same edge in SHIFT -> bit discarded, count=0.
//     rst with zeroize -> reset values.

Source files
------------

// File: rtl/key_loader.sv
// Serial key loader with even-parity check, fail counting and permanent lockout.
// Drives the locked core's parallel key; the key stays zero until a clean load.
module key_loader #(
    parameter int KEY_W    = 8,
    parameter int MAX_FAIL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             zeroize,
    input  logic             key_in_valid,
    input  logic             key_in_bit,
    output logic             key_in_ready,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             busy,
    output logic             error,
    output logic             lockout
);

    localparam int CW = $clog2(KEY_W + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SHIFT   = 3'd1;
    localparam logic [2:0] S_PARITY  = 3'd2;
    localparam logic [2:0] S_LOADED  = 3'd3;
    localparam logic [2:0] S_ERROR   = 3'd4;
    localparam logic [2:0] S_LOCKOUT = 3'd5;

    localparam logic [CW-1:0] CNT_LAST = CW'(KEY_W - 1);
    localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);

    logic [2:0]       state_q, state_d;
    logic [KEY_W-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [FW-1:0]    fail_q, fail_d;
    logic [KEY_W-1:0] key_q, key_d;

    logic             xfer;
    logic             locked;
    logic [FW-1:0]    fail_inc;

    assign locked   = (state_q == S_LOCKOUT);
    assign xfer     = key_in_valid && key_in_ready;
    assign fail_inc = (fail_q == FAIL_MAX) ? fail_q : fail_q + FW'(1);

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        key_d   = key_q;
        if (zeroize && !locked) begin
            state_d = S_IDLE;
            sreg_d  = '0;
            cnt_d   = '0;
            key_d   = '0;
        end else if (start && !locked) begin
            // a bit arriving on this same edge belongs to the abandoned load
            state_d = S_SHIFT;
            sreg_d  = '0;
            cnt_d   = '0;
            key_d   = '0;
        end else if (xfer) begin
            case (state_q)
                S_SHIFT: begin
                    sreg_d = {key_in_bit, sreg_q[KEY_W-1:1]};
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (key_in_bit == ^sreg_q) begin
                        key_d   = sreg_q;
                        fail_d  = '0;
                        state_d = S_LOADED;
                    end else begin
                        key_d   = '0;
                        fail_d  = fail_inc;
                        state_d = (fail_inc == FAIL_MAX) ? S_LOCKOUT : S_ERROR;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            key_q   <= key_d;
        end
    end

    assign key          = key_q;
    assign key_valid    = (state_q == S_LOADED);
    assign busy         = (state_q == S_SHIFT) || (state_q == S_PARITY);
    assign key_in_ready = busy;
    assign error        = (state_q == S_ERROR) || locked;
    assign lockout      = locked;

endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader (KEY_W=8, MAX_FAIL=3).
// Flags are packed as {ready, busy, key_valid, error, lockout}.
module tb_key_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       zeroize;
    logic       key_in_valid;
    logic       key_in_bit;
    logic       key_in_ready;
    logic [7:0] key;
    logic       key_valid;
    logic       busy;
    logic       error;
    logic       lockout;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [4:0] F_IDLE   = 5'b00000;
    localparam logic [4:0] F_BUSY   = 5'b11000;
    localparam logic [4:0] F_LOADED = 5'b00100;
    localparam logic [4:0] F_ERROR  = 5'b00010;
    localparam logic [4:0] F_LOCK   = 5'b00011;

    key_loader #(.KEY_W(8), .MAX_FAIL(3)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .zeroize(zeroize),
        .key_in_valid(key_in_valid),
        .key_in_bit(key_in_bit),
        .key_in_ready(key_in_ready),
        .key(key),
        .key_valid(key_valid),
        .busy(busy),
        .error(error),
        .lockout(lockout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] fexp,
                       input logic [7:0] kexp);
        logic [4:0] fobs;
        fobs = {key_in_ready, busy, key_valid, error, lockout};
        n_chk++;
        assert (fobs === fexp) else begin
            n_err++;
            $error("FAIL %s flags obs=%b exp=%b", tag, fobs, fexp);
        end
        n_chk++;
        assert (key === kexp) else begin
            n_err++;
            $error("FAIL %s key obs=%h exp=%h", tag, key, kexp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // v[8] is the parity bit, v[7:0] the key sent LSB first
    task automatic send(input logic [8:0] v, input int nbits, input bit gap);
        for (int i = 0; i < nbits; i++) begin
            key_in_valid = 1'b1;
            key_in_bit   = v[i];
            tick();
            if (gap) begin
                key_in_valid = 1'b0;
                key_in_bit   = ~v[i];
                tick();
            end
        end
        key_in_valid = 1'b0;
        key_in_bit   = 1'b0;
    endtask

    task automatic bad_load();
        pulse_start();
        send({1'b0, 8'h01}, 9, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        zeroize = 1'b0;
        key_in_valid = 1'b0;
        key_in_bit = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset", F_IDLE, 8'h00);

        // valid without ready is ignored in IDLE
        key_in_valid = 1'b1;
        tick();
        key_in_valid = 1'b0;
        chk("idle_valid", F_IDLE, 8'h00);

        pulse_start();
        chk("start_shift", F_BUSY, 8'h00);
        send({1'b0, 8'hA5}, 8, 1'b0);
        chk("parity_wait", F_BUSY, 8'h00);
        send({1'b0, 8'hA5}, 0, 1'b0);
        key_in_valid = 1'b1;
        key_in_bit   = 1'b0;
        tick();
        key_in_valid = 1'b0;
        chk("clean_a5", F_LOADED, 8'hA5);

        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        chk("zeroize_loaded", F_IDLE, 8'h00);

        pulse_start();
        send({1'b0, 8'hA5}, 9, 1'b1);
        chk("gapped_a5", F_LOADED, 8'hA5);

        pulse_start();
        chk("start_in_loaded", F_BUSY, 8'h00);
        send({1'b1, 8'hFF}, 4, 1'b0);
        pulse_start();
        send({1'b0, 8'h3C}, 9, 1'b0);
        chk("restart_3c", F_LOADED, 8'h3C);

        pulse_start();
        send({1'b1, 8'hFF}, 3, 1'b0);
        start        = 1'b1;
        key_in_valid = 1'b1;
        key_in_bit   = 1'b1;
        tick();
        start        = 1'b0;
        key_in_valid = 1'b0;
        send({1'b0, 8'hA5}, 8, 1'b0);
        chk("simul_8bits", F_BUSY, 8'h00);
        key_in_valid = 1'b1;
        key_in_bit   = 1'b0;
        tick();
        key_in_valid = 1'b0;
        chk("simul_a5", F_LOADED, 8'hA5);

        bad_load();
        chk("bad1", F_ERROR, 8'h00);
        bad_load();
        chk("bad2", F_ERROR, 8'h00);
        bad_load();
        chk("bad3_lock", F_LOCK, 8'h00);

        pulse_start();
        chk("lock_start", F_LOCK, 8'h00);
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        chk("lock_zeroize", F_LOCK, 8'h00);
        send({1'b0, 8'hA5}, 9, 1'b0);
        chk("lock_bits", F_LOCK, 8'h00);

        rst     = 1'b1;
        zeroize = 1'b1;
        tick();
        rst     = 1'b0;
        zeroize = 1'b0;
        chk("rst_zeroize", F_IDLE, 8'h00);

        bad_load();
        chk("fr_bad1", F_ERROR, 8'h00);
        bad_load();
        chk("fr_bad2", F_ERROR, 8'h00);
        pulse_start();
        send({1'b0, 8'h3C}, 9, 1'b0);
        chk("fr_good_3c", F_LOADED, 8'h3C);
        bad_load();
        chk("fr_bad3", F_ERROR, 8'h00);
        bad_load();
        chk("fr_bad4", F_ERROR, 8'h00);

        // rst mid-load also clears the two accumulated failures
        pulse_start();
        send({1'b0, 8'hA5}, 4, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_midload", F_IDLE, 8'h00);
        bad_load();
        chk("post_rst_bad", F_ERROR, 8'h00);

        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        chk("zeroize_error", F_IDLE, 8'h00);
        bad_load();
        chk("zeroize_keeps_fail", F_ERROR, 8'h00);
        bad_load();
        chk("zeroize_then_lock", F_LOCK, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
